// File: rtl/isp_frame_mem_ahb_slave.sv
// AHB-lite frame-buffer slave for the ISP read/write DMA masters.
// Word RAM with byte-lane writes, programmable wait states and two-cycle ERROR responses.
module isp_frame_mem_ahb_slave #(
  parameter int unsigned AW          = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        n_hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic        hready_out,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [2:0]  WS    = 3'(WAIT_STATES);

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          pend_wr_q, pend_wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem_q [DEPTH];

  logic [31:0]   off;
  logic          accept;
  logic          acc_err;
  logic          commit;
  logic [AW-1:0] acc_word;
  logic [3:0]    acc_be;
  logic [31:0]   fwd_word;
  logic          unused_ok;

  assign unused_ok = ^{hburst, htrans[0]};

  assign hready_out = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign hresp      = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
  assign hrdata     = rdata_q;

  // Address phases are only taken while our own data phase is completing or idle.
  assign off      = haddr - BASE_ADDR;
  assign accept   = hsel & hready_in & htrans[1] & hready_out;
  assign acc_word = off[AW+1:2];
  assign acc_err  = (off[31:AW+2] != '0)
                 || (hsize > 3'b010)
                 || ((hsize == 3'b001) && off[0])
                 || ((hsize == 3'b010) && (off[1:0] != 2'b00));

  // A pending valid write lands on the edge that closes its data phase.
  assign commit = hready_out & pend_q & pend_wr_q;

  // NOTE: every always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    acc_be = 4'b1111;
    case (hsize)
      3'b000:  acc_be = 4'b0001 << off[1:0];
      3'b001:  acc_be = off[1] ? 4'b1100 : 4'b0011;
      default: ;
    endcase
  end

  // Read of the word being committed this edge sees the merged lanes.
  always_comb begin
    fwd_word = mem_q[acc_word];
    if (commit && (addr_q == acc_word)) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) fwd_word[8*i +: 8] = hwdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    addr_d    = addr_q;
    be_d      = be_q;
    rdata_d   = rdata_q;

    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = ST_IDLE;
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_IDLE;
      default: ;
    endcase

    if (hready_out) begin
      pend_d = 1'b0;
      if (accept) begin
        if (acc_err) begin
          state_d = ST_ERR1;
        end else begin
          pend_d    = 1'b1;
          pend_wr_d = hwrite;
          addr_d    = acc_word;
          be_d      = acc_be;
          if (!hwrite) rdata_d = fwd_word;
          if (WS != 3'd0) begin
            state_d = ST_WAIT;
            cnt_d   = WS;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge hclk) begin
    if (!n_hreset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      pend_q    <= 1'b0;
      pend_wr_q <= 1'b0;
      addr_q    <= '0;
      be_q      <= 4'b0000;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      rdata_q   <= rdata_d;
    end
  end

  // NOTE: the RAM array has no reset so it maps onto an SRAM macro; reset only blocks the write.
  always_ff @(posedge hclk) begin
    if (n_hreset && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem_q[addr_q][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

endmodule
